// File: rtl/muldiv_unit.sv
// Iterative RV64M-style multiply/divide unit: one shift-add or restoring shift-subtract step per cycle.
// Build option MULDIV_SIGNED_EN enables MULH/MULHSU/DIV/REM; otherwise they complete at once flagged illegal.
module muldiv_unit #(
    parameter int xlen = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [xlen-1:0] rs1_data,
    input  logic [xlen-1:0] rs2_data,
    input  logic [4:0]      rd,
    output logic            busy,
    output logic            done,
    output logic [4:0]      rd_out,
    output logic [xlen-1:0] rd_data,
    output logic            write_en,
    output logic            illegal
);
    localparam int            CW   = $clog2(xlen + 1);
    localparam logic [CW-1:0] LAST = CW'(xlen);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic [xlen-1:0] opnd_q, opnd_d;
    logic [xlen-1:0] hi_q, hi_d;
    logic [xlen-1:0] lo_q, lo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            write_en_q, write_en_d;
    logic            illegal_q, illegal_d;
    logic [4:0]      rd_out_q, rd_out_d;
    logic [xlen-1:0] rd_data_q, rd_data_d;

    logic              accept;
    logic              op_illegal;
    logic [xlen-1:0]   mag_a, mag_b;
    logic [2*xlen-1:0] prod_raw, prod_fix;
    logic [xlen-1:0]   quo_fix, rem_fix;
    logic [xlen:0]     mul_sum, rem_sh, rem_diff;

    assign accept   = (state_q == IDLE) && start;
    assign prod_raw = {hi_q, lo_q};

`ifdef MULDIV_SIGNED_EN
    // Signed ops run on magnitudes; the sign flags captured at start drive the final correction.
    logic neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic start_neg_a, start_neg_b;

    always_comb begin
        start_neg_a = rs1_data[xlen-1] && (funct3 inside {3'b001, 3'b010, 3'b100, 3'b110});
        start_neg_b = rs2_data[xlen-1] && (funct3 inside {3'b001, 3'b100, 3'b110});
        neg_a_d     = accept ? start_neg_a : neg_a_q;
        neg_b_d     = accept ? start_neg_b : neg_b_q;
        mag_a       = start_neg_a ? -rs1_data : rs1_data;
        mag_b       = start_neg_b ? -rs2_data : rs2_data;
        prod_fix    = (neg_a_q ^ neg_b_q) ? -prod_raw : prod_raw;
        // A zero divisor yields all-ones regardless of the dividend sign.
        if (opnd_q == '0) begin
            quo_fix = '1;
        end else begin
            quo_fix = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
        end
        rem_fix    = neg_a_q ? -hi_q : hi_q;
        op_illegal = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
        end else begin
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
        end
    end
`else
    always_comb begin
        mag_a    = rs1_data;
        mag_b    = rs2_data;
        prod_fix = prod_raw;
        quo_fix  = lo_q;
        rem_fix  = hi_q;
        case (funct3)
            3'b001, 3'b010, 3'b100, 3'b110: op_illegal = 1'b1;
            default:                        op_illegal = 1'b0;
        endcase
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        rd_d       = rd_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        write_en_d = 1'b0;
        illegal_d  = 1'b0;
        rd_out_d   = rd_out_q;
        rd_data_d  = rd_data_q;

        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = {hi_q, lo_q[xlen-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = funct3[1:0];
                    rd_d  = rd;
                    cnt_d = '0;
                    hi_d  = '0;
                    if (op_illegal) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        illegal_d = 1'b1;
                        rd_out_d  = rd;
                        rd_data_d = '0;
                    end else if (!funct3[2]) begin
                        state_d = MUL;
                        opnd_d  = mag_a;
                        lo_d    = mag_b;
                    end else begin
                        state_d = DIV;
                        opnd_d  = mag_b;
                        lo_d    = mag_a;
                    end
                end
            end
            MUL: begin
                if (cnt_q == LAST) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    write_en_d = (rd_q != 5'd0);
                    rd_out_d   = rd_q;
                    rd_data_d  = (op_q == 2'b00) ? prod_fix[xlen-1:0] : prod_fix[2*xlen-1:xlen];
                end else begin
                    hi_d  = mul_sum[xlen:1];
                    lo_d  = {mul_sum[0], lo_q[xlen-1:1]};
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DIV: begin
                if (cnt_q == LAST) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    write_en_d = (rd_q != 5'd0);
                    rd_out_d   = rd_q;
                    rd_data_d  = op_q[1] ? rem_fix : quo_fix;
                end else begin
                    // Borrow out of the trial subtraction means restore the shifted remainder.
                    hi_d  = rem_diff[xlen] ? rem_sh[xlen-1:0] : rem_diff[xlen-1:0];
                    lo_d  = {lo_q[xlen-2:0], ~rem_diff[xlen]};
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            write_en_q <= 1'b0;
            illegal_q  <= 1'b0;
            rd_out_q   <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            write_en_q <= write_en_d;
            illegal_q  <= illegal_d;
            rd_out_q   <= rd_out_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign write_en = write_en_q;
    assign illegal  = illegal_q;
    assign rd_out   = rd_out_q;
    assign rd_data  = rd_data_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (xlen=64); signed expectations follow MULDIV_SIGNED_EN.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [2:0]  funct3;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [4:0]  rd;
    logic        busy;
    logic        done;
    logic [4:0]  rd_out;
    logic [63:0] rd_data;
    logic        write_en;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    always #5 clk = ~clk;

    muldiv_unit #(.xlen(64)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd       (rd),
        .busy     (busy),
        .done     (done),
        .rd_out   (rd_out),
        .rd_data  (rd_data),
        .write_en (write_en),
        .illegal  (illegal)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Drive one request so it is sampled on the next edge, then scramble the inputs.
    task automatic issue(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] r);
        @(negedge clk);
        funct3   = f;
        rs1_data = a;
        rs2_data = b;
        rd       = r;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        funct3   = ~f;
        rs1_data = ~a;
        rs2_data = ~b;
        rd       = ~r;
    endtask

    // Counts edges after the start-sampling edge until done is seen (bounded).
    task automatic wait_done(input int from, output int edges);
        edges = from;
        while (done !== 1'b1 && edges < from + 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic finish_op(input string tag, input logic [4:0] r, input logic [63:0] exp,
                             input logic exp_we, input logic exp_ill, input int lat, input int edges);
        check({tag, " latency"}, 64'(edges), 64'(lat));
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " write_en"}, 64'(write_en), 64'(exp_we));
        check({tag, " illegal"}, 64'(illegal), 64'(exp_ill));
        check({tag, " rd_data"}, rd_data, exp);
        if (!exp_ill) check({tag, " rd_out"}, 64'(rd_out), 64'(r));
        $display("op %s: rd_out=%0d rd_data=0x%h we=%b ill=%b edges=%0d",
                 tag, rd_out, rd_data, write_en, illegal, edges);
        @(posedge clk);
        #1;
        check({tag, " done drop"}, 64'(done), 64'd0);
        check({tag, " we drop"}, 64'(write_en), 64'd0);
        check({tag, " ill drop"}, 64'(illegal), 64'd0);
        check({tag, " hold"}, rd_data, exp);
        check({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    task automatic do_op(input string tag, input logic [2:0] f, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] r, input logic [63:0] exp,
                         input logic exp_we, input logic exp_ill);
        int edges;
        issue(f, a, b, r);
        check({tag, " busy"}, 64'(busy), 64'd1);
        wait_done(0, edges);
        finish_op(tag, r, exp, exp_we, exp_ill, exp_ill ? 0 : 65, edges);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        rstn     = 1'b0;
        start    = 1'b1;
        funct3   = 3'b011;
        rs1_data = ONES;
        rs2_data = 64'd2;
        rd       = 5'd5;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst busy", 64'(busy), 64'd0);
            check("rst done", 64'(done), 64'd0);
            check("rst we", 64'(write_en), 64'd0);
            check("rst data", rd_data, 64'd0);
        end
        @(negedge clk);
        rstn  = 1'b1;
        start = 1'b0;

        do_op("mulhu", 3'b011, ONES, 64'd2, 5'd5, 64'd1, 1'b1, 1'b0);
        do_op("divu0", 3'b101, 64'd100, 64'd0, 5'd3, ONES, 1'b1, 1'b0);
        do_op("remu0", 3'b111, 64'd100, 64'd0, 5'd0, 64'd100, 1'b0, 1'b0);
        do_op("mul", 3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1, 1'b0);
        do_op("divu", 3'b101, 64'd100, 64'd7, 5'd2, 64'd14, 1'b1, 1'b0);
        do_op("remu", 3'b111, 64'd100, 64'd7, 5'd2, 64'd2, 1'b1, 1'b0);
        do_op("mulhu2", 3'b011, MINV, 64'd4, 5'd6, 64'd2, 1'b1, 1'b0);
`ifdef MULDIV_SIGNED_EN
        do_op("div", 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0);
        do_op("rem", 3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, ONES, 1'b1, 1'b0);
        do_op("divovf", 3'b100, MINV, ONES, 5'd8, MINV, 1'b1, 1'b0);
        do_op("removf", 3'b110, MINV, ONES, 5'd8, 64'd0, 1'b1, 1'b0);
        do_op("mulh", 3'b001, ONES, ONES, 5'd8, 64'd0, 1'b1, 1'b0);
        do_op("mulhsu", 3'b010, ONES, 64'd2, 5'd8, ONES, 1'b1, 1'b0);
        do_op("div0s", 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 5'd8, ONES, 1'b1, 1'b0);
        do_op("rem0s", 3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 5'd8, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0);
`else
        do_op("div ill", 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, 64'd0, 1'b0, 1'b1);
        do_op("rem ill", 3'b110, 64'd9, 64'd2, 5'd8, 64'd0, 1'b0, 1'b1);
        do_op("mulh ill", 3'b001, ONES, ONES, 5'd8, 64'd0, 1'b0, 1'b1);
        do_op("mulhsu ill", 3'b010, ONES, 64'd2, 5'd8, 64'd0, 1'b0, 1'b1);
`endif

        // A second start mid-multiply must not disturb the running op.
        issue(3'b000, 64'd6, 64'd7, 5'd9);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        funct3   = 3'b101;
        rs1_data = 64'd1000;
        rs2_data = 64'd10;
        rd       = 5'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("midstart busy", 64'(busy), 64'd1);
        wait_done(11, edges);
        finish_op("midstart", 5'd9, 64'd42, 1'b1, 1'b0, 65, edges);

        // Reset at iteration 30 abandons the op; the restart after it must run a full 65 edges.
        issue(3'b011, ONES, 64'd2, 5'd7);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
        end
        rstn  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst we", 64'(write_en), 64'd0);
        check("midrst data", rd_data, 64'd0);
        rstn = 1'b1;
        issue(3'b011, ONES, ONES, 5'd10);
        check("restart busy", 64'(busy), 64'd1);
        wait_done(0, edges);
        finish_op("restart", 5'd10, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 65, edges);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
